// File: rtl/bid_tenure_sched.sv
// Registered bidding scheduler: four masters bid against credit balances for
// bus tenure; the winner holds the bus until done, request drop or tenure limit.
module bid_tenure_sched #(
  parameter int BID_W         = 8,
  parameter int BAL_W         = 12,
  parameter int INIT_BAL      = 900,
  parameter int MAX_BAL       = 1000,
  parameter int REFILL_PERIOD = 64,
  parameter int REFILL_AMT    = 100,
  parameter int MAX_TENURE    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*BID_W-1:0] bid,
  input  logic [3:0]         done,
  output logic [3:0]         grant,
  output logic               grant_vld,
  output logic [1:0]         grant_id,
  output logic               busy,
  output logic [4*BAL_W-1:0] bal,
  output logic               refill_pulse
);

  localparam int CNT_W = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;
  localparam int TEN_W = $clog2(MAX_TENURE + 1);
  localparam int CMP_W = (BID_W > BAL_W) ? BID_W : BAL_W;

  localparam logic [0:0]       ST_IDLE   = 1'b0;
  localparam logic [0:0]       ST_OWN    = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFILL_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [TEN_W-1:0] TEN_MAX   = TEN_W'(MAX_TENURE);
  localparam logic [TEN_W-1:0] TEN_ONE   = TEN_W'(1);
  localparam logic [TEN_W-1:0] TEN_ZERO  = TEN_W'(0);
  localparam logic [BAL_W-1:0] BAL_INIT  = BAL_W'(INIT_BAL);
  localparam logic [BAL_W-1:0] BAL_ZERO  = BAL_W'(0);
  localparam logic [BAL_W:0]   BAL_MAX_X = (BAL_W+1)'(MAX_BAL);
  localparam logic [BAL_W:0]   REFILL_X  = (BAL_W+1)'(REFILL_AMT);
  localparam logic [BAL_W:0]   ZERO_X    = (BAL_W+1)'(0);

  logic [0:0]       state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic             grant_vld_q;
  logic [1:0]       gid_q, gid_d;
  logic [1:0]       last_q, last_d;
  logic [TEN_W-1:0] ten_q, ten_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             refill_pulse_q;
  logic [BAL_W-1:0] bal_q [4];
  logic [BAL_W-1:0] bal_d [4];

  logic [BAL_W-1:0] eff_s [4];
  logic [3:0]       elig_s;
  logic             win_found_s;
  logic [1:0]       win_id_s;
  logic [BAL_W-1:0] win_eff_s;
  logic             release_s;
  logic             refill_now_s;

  // Effective bid is the bid clipped to the remaining balance.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (CMP_W'(bid[i*BID_W +: BID_W]) < CMP_W'(bal_q[i])) begin
        eff_s[i] = BAL_W'(bid[i*BID_W +: BID_W]);
      end else begin
        eff_s[i] = bal_q[i];
      end
      elig_s[i] = req[i] && (eff_s[i] != BAL_ZERO);
    end
  end

  // Largest effective bid wins; strict compare keeps the earliest round-robin slot on ties.
  always_comb begin
    logic [1:0] idx;
    idx         = 2'd0;
    win_found_s = 1'b0;
    win_id_s    = 2'd0;
    win_eff_s   = BAL_ZERO;
    for (int k = 0; k < 4; k++) begin
      idx = last_q + 2'(k + 1);
      if (elig_s[idx] && (!win_found_s || (eff_s[idx] > win_eff_s))) begin
        win_found_s = 1'b1;
        win_id_s    = idx;
        win_eff_s   = eff_s[idx];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Grant FSM next state.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gid_d     = gid_q;
    last_d    = last_q;
    ten_d     = ten_q;
    release_s = done[gid_q] || !req[gid_q] || (ten_q == TEN_MAX);
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d = ST_OWN;
          grant_d = 4'b0001 << win_id_s;
          gid_d   = win_id_s;
          last_d  = win_id_s;
          ten_d   = TEN_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (release_s) begin
          state_d = ST_IDLE;
          grant_d = 4'b0000;
        end else begin
          ten_d = ten_q + TEN_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  // Refill counter free-runs independent of the FSM.
  always_comb begin
    refill_now_s = (cnt_q == CNT_LAST);
    if (refill_now_s) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Charge the winner, then add refill and saturate in one extra bit of headroom.
  always_comb begin
    logic [BAL_W:0] sum;
    logic [BAL_W:0] charge;
    sum    = ZERO_X;
    charge = ZERO_X;
    for (int i = 0; i < 4; i++) begin
      if ((state_q == ST_IDLE) && win_found_s && (win_id_s == 2'(i))) begin
        charge = {1'b0, win_eff_s};
      end else begin
        charge = ZERO_X;
      end
      sum = {1'b0, bal_q[i]} - charge + (refill_now_s ? REFILL_X : ZERO_X);
      if (sum > BAL_MAX_X) begin
        bal_d[i] = BAL_MAX_X[BAL_W-1:0];
      end else begin
        bal_d[i] = sum[BAL_W-1:0];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      grant_q        <= 4'b0000;
      grant_vld_q    <= 1'b0;
      gid_q          <= 2'd0;
      last_q         <= 2'd3;
      ten_q          <= TEN_ZERO;
      cnt_q          <= CNT_ZERO;
      refill_pulse_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        bal_q[i] <= BAL_INIT;
      end
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      grant_vld_q    <= |grant_d;
      gid_q          <= gid_d;
      last_q         <= last_d;
      ten_q          <= ten_d;
      cnt_q          <= cnt_d;
      refill_pulse_q <= (cnt_d == CNT_LAST);
      for (int i = 0; i < 4; i++) begin
        bal_q[i] <= bal_d[i];
      end
    end
  end

  // Pack balances onto the output bus.
  always_comb begin
    bal = '0;
    for (int i = 0; i < 4; i++) begin
      bal[i*BAL_W +: BAL_W] = bal_q[i];
    end
  end

  assign grant        = grant_q;
  assign grant_vld    = grant_vld_q;
  assign grant_id     = gid_q;
  assign busy         = (state_q == ST_OWN);
  assign refill_pulse = refill_pulse_q;

endmodule

// File: tb/tb_bid_tenure_sched.sv
// Bench for bid_tenure_sched: directed scenarios with literal expectations plus
// randomized traffic, all outputs compared every cycle against a behavioural model.
module tb_bid_tenure_sched;

  localparam int BID_W    = 8;
  localparam int BAL_W    = 12;
  localparam int INIT_BAL = 900;
  localparam int MAX_BAL  = 1000;
  localparam int PERIOD   = 64;
  localparam int AMT      = 100;
  localparam int MAXT     = 16;

  logic               clk  = 1'b0;
  logic               rst  = 1'b0;
  logic [3:0]         req  = 4'd0;
  logic [3:0]         done = 4'd0;
  logic [4*BID_W-1:0] bid  = '0;
  logic [3:0]         grant;
  logic               grant_vld;
  logic [1:0]         grant_id;
  logic               busy;
  logic [4*BAL_W-1:0] bal;
  logic               refill_pulse;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bid_tenure_sched #(
    .BID_W(BID_W), .BAL_W(BAL_W), .INIT_BAL(INIT_BAL), .MAX_BAL(MAX_BAL),
    .REFILL_PERIOD(PERIOD), .REFILL_AMT(AMT), .MAX_TENURE(MAXT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .bid(bid), .done(done),
    .grant(grant), .grant_vld(grant_vld), .grant_id(grant_id), .busy(busy),
    .bal(bal), .refill_pulse(refill_pulse)
  );

  // Model state: owner -1 means nobody holds the bus.
  int m_bal [4];
  int m_owner, m_gid, m_last, m_ten, m_edges;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int bid_of(int i);
    return int'(bid[i*BID_W +: BID_W]);
  endfunction

  function automatic int bal_of(int i);
    return int'(bal[i*BAL_W +: BAL_W]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_bal[i] = INIT_BAL;
    m_owner = -1;
    m_gid   = 0;
    m_last  = 3;
    m_ten   = 0;
    m_edges = 0;
  endtask

  task automatic model_step();
    int nb [4];
    int best, beste, e, i;
    bit refill;
    refill = ((m_edges % PERIOD) == PERIOD - 1);
    nb = m_bal;
    if (m_owner < 0) begin
      best = -1;
      beste = 0;
      for (int k = 0; k < 4; k++) begin
        i = (m_last + 1 + k) % 4;
        e = (bid_of(i) < m_bal[i]) ? bid_of(i) : m_bal[i];
        if (req[i] && e > 0 && (best < 0 || e > beste)) begin
          best = i;
          beste = e;
        end
      end
      if (best >= 0) begin
        nb[best] = nb[best] - beste;
        m_owner = best;
        m_gid = best;
        m_last = best;
        m_ten = 1;
      end
    end else if (done[m_owner] || !req[m_owner] || m_ten == MAXT) begin
      m_owner = -1;
    end else begin
      m_ten++;
    end
    if (refill) begin
      for (int k = 0; k < 4; k++) nb[k] = (nb[k] + AMT > MAX_BAL) ? MAX_BAL : nb[k] + AMT;
    end
    m_bal = nb;
    m_edges++;
  endtask

  // Model advances on each clock edge and collapses on reset.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // Single compare process: every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
      check("grant_vld", grant_vld, (m_owner >= 0) ? 1 : 0);
      check("grant_id", grant_id, m_gid);
      check("busy", busy, (m_owner >= 0) ? 1 : 0);
      check("refill_pulse", refill_pulse, ((m_edges % PERIOD) == PERIOD - 1) ? 1 : 0);
      for (int i = 0; i < 4; i++) check($sformatf("bal%0d", i), bal_of(i), m_bal[i]);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_bid(input int i, input int v);
    bid[i*BID_W +: BID_W] = BID_W'(v);
  endtask

  // Called just after a falling edge; leaves reset released at the next falling edge.
  task automatic pulse_reset();
    #2 rst = 1'b0;
    tick(1);
    rst = 1'b1;
  endtask

  task automatic wait_refill(input string nm);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (refill_pulse === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
    check(nm, found, 1);
  endtask

  initial begin
    int exp4 [4];
    int n;
    exp4 = '{645, 390, 135, 0};

    tick(3);
    check("rst_grant", grant, 0);
    check("rst_gid", grant_id, 0);
    check("rst_bal0", bal_of(0), 900);
    check("rst_bal3", bal_of(3), 900);

    // Single requester with a modest bid.
    rst = 1'b1;
    req = 4'b0001;
    set_bid(0, 50);
    tick(1);
    check("t1_grant", grant, 1);
    check("t1_bal0", bal_of(0), 850);
    done = 4'b0001;
    tick(1);
    check("t1_release", grant, 0);
    done = 4'b0000;
    req  = 4'b0000;

    // Highest bid wins.
    req = 4'b1111;
    set_bid(0, 10); set_bid(1, 200); set_bid(2, 30); set_bid(3, 40);
    tick(1);
    check("t2_grant", grant, 4'b0010);
    check("t2_bal1", bal_of(1), 700);
    check("t2_bal2", bal_of(2), 900);
    check("t2_bal3", bal_of(3), 900);
    done = 4'b0010;
    tick(1);
    done = 4'b0000;
    req  = 4'b0000;

    // Equal bids rotate round-robin from a fresh reset.
    pulse_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_bid(i, 20);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check($sformatf("t3_grant%0d", k), grant, 1 << (k % 4));
      done = 4'(1 << (k % 4));
      tick(1);
      check($sformatf("t3_idle%0d", k), grant, 0);
      done = 4'b0000;
    end
    req = 4'b0000;

    // Draining one master to zero, then winning again only after a refill.
    pulse_reset();
    req  = 4'b0100;
    done = 4'b0100;
    set_bid(2, 255);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check($sformatf("t4_grant%0d", k), grant, 4'b0100);
      check($sformatf("t4_bal2_%0d", k), bal_of(2), exp4[k]);
      tick(1);
      check($sformatf("t4_idle%0d", k), grant, 0);
    end
    wait_refill("t4_refill_seen");
    check("t4_starved", grant, 0);
    tick(1);
    check("t4_refilled", bal_of(2), 100);
    check("t4_no_grant", grant, 0);
    tick(1);
    check("t4_regrant", grant, 4'b0100);
    check("t4_bal2_end", bal_of(2), 0);
    tick(1);
    done = 4'b0000;
    req  = 4'b0000;

    // Tenure limit.
    req = 4'b0001;
    set_bid(0, 1);
    tick(1);
    n = 0;
    while (grant == 4'b0001 && n < 40) begin
      n++;
      tick(1);
    end
    check("t5_tenure", n, MAXT);
    check("t5_gap", grant, 0);
    tick(1);
    check("t5_regrant", grant, 4'b0001);
    req = 4'b0000;
    tick(2);

    // Saturation, charge plus refill on one edge, and reset mid-tenure.
    pulse_reset();
    wait_refill("t6_refill1");
    tick(1);
    for (int i = 0; i < 4; i++) check($sformatf("t6_sat%0d", i), bal_of(i), 1000);
    wait_refill("t6_refill2");
    req = 4'b1000;
    set_bid(3, 50);
    tick(1);
    check("t6_grant", grant, 4'b1000);
    check("t6_bal3", bal_of(3), 1000);
    #2 rst = 1'b0;
    #1;
    check("t6_async_grant", grant, 0);
    check("t6_async_vld", grant_vld, 0);
    check("t6_async_bal3", bal_of(3), 900);
    check("t6_async_bal0", bal_of(0), 900);
    tick(1);
    rst = 1'b1;
    req = 4'b0000;

    // Randomized traffic with ties, drains and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        req[i]  = ($urandom_range(0, 9) < 8);
        done[i] = ($urandom_range(0, 5) == 0);
        case ($urandom_range(0, 3))
          0: set_bid(i, $urandom_range(0, 5));
          1: set_bid(i, 255);
          default: set_bid(i, $urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 399) == 0) pulse_reset();
      else tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
